// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults and the per-axis decode payload.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned FRAME_CNT_W = 8;

    // Decode of an axis counter's next value, consumed by the output flops.
    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               active;
        logic               sync;
    } axis_dec_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap counter with advance enable, wrap flag and window
// decode of the value the counter will hold after this edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned FP     = H_FP_DEF,
    parameter int unsigned SYNC   = H_SYNC_DEF,
    parameter int unsigned BP     = H_BP_DEF
) (
    input  logic      clk_i,
    input  logic      rst_,
    input  logic      inc,
    output logic      wrap_c,
    output axis_dec_t dec_c
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
    localparam int unsigned W     = $clog2(TOTAL + 1);

    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt_c;

    // Next count and its decode; resting at LAST makes the first advance land on 0.
    always_comb begin
        wrap_c    = inc && (cnt == LAST);
        cnt_nxt_c = cnt;
        dec_c     = '0;
        if (wrap_c) begin
            cnt_nxt_c = '0;
        end else if (inc) begin
            cnt_nxt_c = cnt + W'(1);
        end
        dec_c.pos    = COORD_W'(cnt_nxt_c);
        dec_c.active = (cnt_nxt_c < ACT_END);
        dec_c.sync   = (cnt_nxt_c >= SYNC_BEG) && (cnt_nxt_c < SYNC_END);
    end

    always_ff @(posedge clk_i or negedge rst_) begin
        if (!rst_) begin
            cnt <= LAST;
        end else begin
            cnt <= cnt_nxt_c;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/position generator; all outputs registered from the next (h,v).
// Optional 8-bit frame counter output enabled by VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic               clk_i,
    input  logic               rst_,
    input  logic               en_i,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               video_on_o,
    output logic [COORD_W-1:0] pix_x_o,
    output logic [COORD_W-1:0] pix_y_o,
    output logic               line_start_o,
    output logic               frame_start_o
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
`endif
);

    axis_dec_t h_dec_c;
    axis_dec_t v_dec_c;
    logic      h_wrap_c;
    logic      v_wrap_c;
    logic      video_nxt_c;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk_i  (clk_i),
        .rst_   (rst_),
        .inc    (en_i),
        .wrap_c (h_wrap_c),
        .dec_c  (h_dec_c)
    );

    // Vertical axis steps only on the horizontal wrap; its wrap marks (0,0).
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk_i  (clk_i),
        .rst_   (rst_),
        .inc    (h_wrap_c),
        .wrap_c (v_wrap_c),
        .dec_c  (v_dec_c)
    );

    assign video_nxt_c = h_dec_c.active && v_dec_c.active;

    always_ff @(posedge clk_i or negedge rst_) begin
        if (!rst_) begin
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
            video_on_o    <= 1'b0;
            pix_x_o       <= '0;
            pix_y_o       <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            line_start_o  <= h_wrap_c;
            frame_start_o <= v_wrap_c;
            if (en_i) begin
                hsync_o    <= ~h_dec_c.sync;
                vsync_o    <= ~v_dec_c.sync;
                video_on_o <= video_nxt_c;
                pix_x_o    <= video_nxt_c ? h_dec_c.pos : '0;
                pix_y_o    <= video_nxt_c ? v_dec_c.pos : '0;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk_i or negedge rst_) begin
        if (!rst_) begin
            frame_cnt_o <= '0;
        end else if (v_wrap_c) begin
            frame_cnt_o <= frame_cnt_o + FRAME_CNT_W'(1);
        end
    end
`endif

endmodule
